// File: rtl/hamming_decoder_rx.sv
// Serial Hamming(7,4) receiver: collects c1..c7, corrects any single-bit error,
// then shifts out the corrected nibble d1..d4 with a valid strobe.
module hamming_decoder_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic       data_in,
  output logic       ready,
  output logic       data_out,
  output logic       out_valid,
  output logic       err_flag,
  output logic [2:0] syndrome,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    CORRECT = 2'd2,
    SEND    = 2'd3
  } state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] cw_q;        // cw_q[0] holds c1, cw_q[6] holds c7
  logic [2:0] out_sr_q;    // d2..d4 still waiting to be shifted out
  logic [1:0] send_cnt_q;
  logic       ready_q;
  logic       data_out_q;
  logic       out_valid_q;
  logic       err_flag_q;
  logic [2:0] syndrome_q;
  logic [7:0] err_count_q;

  logic [2:0] syn_d;
  logic [7:0] flip_d;
  logic [6:0] fixed_d;
  logic [3:0] nibble_d;    // {d1, d2, d3, d4}

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    syn_d[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6];
    syn_d[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6];
    syn_d[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];
    // Bit 0 of the one-hot mask stands for "no error" and is dropped.
    flip_d   = 8'b1 << syn_d;
    fixed_d  = cw_q ^ flip_d[7:1];
    nibble_d = {fixed_d[2], fixed_d[4], fixed_d[5], fixed_d[6]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      cw_q        <= 7'd0;
      out_sr_q    <= 3'd0;
      send_cnt_q  <= 2'd0;
      ready_q     <= 1'b1;
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      syndrome_q  <= 3'd0;
      err_count_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            cw_q[0]   <= data_in;
            bit_cnt_q <= 3'd1;
            state_q   <= RECV;
          end
        end

        RECV: begin
          if (valid_in) begin
            cw_q[bit_cnt_q] <= data_in;
            if (bit_cnt_q == 3'd6) begin
              bit_cnt_q <= 3'd0;
              ready_q   <= 1'b0;
              state_q   <= CORRECT;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        CORRECT: begin
          syndrome_q  <= syn_d;
          err_flag_q  <= |syn_d;
          if ((syn_d != 3'd0) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
          end
          data_out_q  <= nibble_d[3];
          out_sr_q    <= nibble_d[2:0];
          out_valid_q <= 1'b1;
          send_cnt_q  <= 2'd0;
          state_q     <= SEND;
        end

        SEND: begin
          if (send_cnt_q == 2'd3) begin
            out_valid_q <= 1'b0;
            data_out_q  <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else begin
            data_out_q <= out_sr_q[2];
            out_sr_q   <= {out_sr_q[1:0], 1'b0};
            send_cnt_q <= send_cnt_q + 2'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err_flag  = err_flag_q;
  assign syndrome  = syndrome_q;
  assign err_count = err_count_q;

endmodule

// File: doc/hamming_decoder_rx.md
# hamming_decoder_rx

Serial-in Hamming(7,4) receiver and single-error corrector, one stage downstream of the serial Hamming encoder. Collects a 7-bit codeword one bit per accepted cycle, computes the 3-bit syndrome, flips the indicated bit, and emits the 4 corrected data bits serially with a valid strobe. Also reports the syndrome and keeps a saturating count of corrected codewords.

## Interface
- No parameters; codeword is fixed at 7 bits, data at 4 bits.
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  a codeword bit is present on data_in this cycle.
- data_in  in  1  serial codeword bit, position c1 first, c7 last.
- ready  out  1  high when the block accepts a bit (IDLE or RECV).
- data_out  out  1  serial corrected data bit, d1 first, d4 last.
- out_valid  out  1  data_out holds a valid data bit this cycle.
- err_flag  out  1  last decoded codeword had a nonzero syndrome.
- syndrome  out  3  last decoded syndrome {s3,s2,s1}.
- err_count  out  8  number of corrected codewords since reset; saturates at 255.

## Operation
- Codeword layout (c1..c7): p1 p2 d1 p3 d2 d3 d4.
- Parity equations: p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
- Syndrome equations: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s3=c4^c5^c6^c7. The value {s3,s2,s1} is the 1-based position of the erroneous bit. If it is 0, no correction is made.
- Single-bit errors, including errors in parity bits, are always corrected. Double errors are silently miscorrected; no detection of them is required.
- State IDLE:
  - ready=1, bit counter=0.
  - valid_in=1 stores the bit as c1 and moves to RECV with counter=1.
- State RECV:
  - ready=1.
  - Each valid_in=1 cycle stores the next bit and increments the counter.
  - valid_in=0 cycles are gaps: nothing is stored and the counter holds.
  - Storing c7 moves to CORRECT.
- State CORRECT (1 cycle):
  - ready=0.
  - Registers the syndrome and err_flag.
  - Registers the corrected nibble {d1..d4}.
  - Increments err_count if the syndrome is nonzero and err_count<255.
  - Moves to SEND.
- State SEND (4 cycles):
  - ready=0, out_valid=1.
  - data_out shifts d1, d2, d3, d4 on consecutive cycles.
  - After d4, moves to IDLE.
- valid_in is ignored whenever ready=0; the sender must hold the bit.
- syndrome and err_flag hold their values until the next CORRECT cycle.
- Reset values: state=IDLE, ready=1, data_out=0, out_valid=0, err_flag=0, syndrome=0, err_count=0, bit counter=0, shift registers=0.
- Reset mid-operation (in RECV, CORRECT or SEND) discards the partial codeword or output immediately. No out_valid is produced after reset until a fresh 7-bit codeword has been received.

## Timing
- E7 is the edge that samples c7.
- Edge E7+1: state=SEND, out_valid=1, data_out=d1, and syndrome, err_flag and err_count are updated.
- Edges E7+2, E7+3, E7+4: data_out=d2, d3, d4.
- Edge E7+5: out_valid=0, ready=1, state=IDLE.
- Latency: d1 is valid 2 cycles after c7 is sampled.
- ready is low for exactly 5 cycles per codeword.
- Back-to-back throughput: 12 cycles per codeword with no gaps (7 receive + 5 busy).
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Clean codeword for data 1011: send c1..c7 = 0,1,1,0,0,1,1 with no gaps.
  - Two cycles after c7: out_valid for 4 cycles with data_out 1,0,1,1.
  - syndrome=0, err_flag=0, err_count=0.
- Data-bit error: send 0,1,1,0,1,1,1 (c5 flipped).
  - syndrome=5, err_flag=1, output 1,0,1,1, err_count=1.
- Parity-bit error: send 1,1,1,0,0,1,1 (c1 flipped).
  - syndrome=1, output 1,0,1,1, err_count increments.
- Gaps and busy input: insert valid_in=0 cycles between bits, and drive valid_in=1 with junk during the 5 busy cycles.
  - Output is unchanged from the gap-free case.
  - The junk is not captured; the next codeword decodes correctly.
- Reset mid-stream: assert reset_n=0 after 4 bits, then send a full clean codeword.
  - Exactly one 4-bit output burst, with correct data.
  - All outputs at reset values during reset.
- Saturation: send 300 codewords each with a single error.
  - err_count reaches 255 and stays at 255.
  - Every output nibble is correct.
